wb_initiator: RTL and testbench

- Wishbone classic single-cycle-transfer initiator (bus master).
- Converts a valid/ready command from local logic into one read or write cycle on the Wishbone bus.
- Returns the read data and completion status on a valid/ready response port.
- Drives the user-project Wishbone responder from on-chip test logic, and is used as the bus driver in responder benches.

---
 rtl/wb_initiator.sv | 149 ++++++++++++++
 tb/tb_wb_initiator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: turns one valid/ready command into one
// bus cycle and reports read data or timeout on a valid/ready response port.
module wb_initiator #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hdeadbeef
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_timeout,
  output logic [15:0] txn_count,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic [7:0]  count, count_n;
  logic        ready_q, ready_n;
  logic        cyc_q, cyc_n;
  logic        we_q, we_n;
  logic [3:0]  sel_q, sel_n;
  logic [31:0] adr_q, adr_n;
  logic [31:0] dat_q, dat_n;
  logic        rsp_valid_q, rsp_valid_n;
  logic [31:0] rsp_dat_q, rsp_dat_n;
  logic        rsp_timeout_q, rsp_timeout_n;
  logic [15:0] txn_q, txn_n;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      count         <= 8'd0;
      ready_q       <= 1'b0;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      sel_q         <= 4'h0;
      adr_q         <= 32'h0;
      dat_q         <= 32'h0;
      rsp_valid_q   <= 1'b0;
      rsp_dat_q     <= 32'h0;
      rsp_timeout_q <= 1'b0;
      txn_q         <= 16'h0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      ready_q       <= ready_n;
      cyc_q         <= cyc_n;
      we_q          <= we_n;
      sel_q         <= sel_n;
      adr_q         <= adr_n;
      dat_q         <= dat_n;
      rsp_valid_q   <= rsp_valid_n;
      rsp_dat_q     <= rsp_dat_n;
      rsp_timeout_q <= rsp_timeout_n;
      txn_q         <= txn_n;
    end
  end

  // Next-state logic computes every output register, so all ports come straight from flops.
  always_comb begin
    state_n       = state;
    count_n       = count;
    ready_n       = ready_q;
    cyc_n         = cyc_q;
    we_n          = we_q;
    sel_n         = sel_q;
    adr_n         = adr_q;
    dat_n         = dat_q;
    rsp_valid_n   = rsp_valid_q;
    rsp_dat_n     = rsp_dat_q;
    rsp_timeout_n = rsp_timeout_q;
    txn_n         = txn_q;

    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (cmd_valid && ready_q) begin
          we_n    = cmd_we;
          adr_n   = cmd_adr;
          dat_n   = cmd_dat;
          cyc_n   = 1'b1;
          sel_n   = 4'hF;
          count_n = 8'd0;
          ready_n = 1'b0;
          state_n = BUS;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout expiring on the same edge.
        if (wbm_ack_i) begin
          cyc_n         = 1'b0;
          sel_n         = 4'h0;
          rsp_dat_n     = we_q ? 32'h0 : wbm_dat_i;
          rsp_timeout_n = 1'b0;
          rsp_valid_n   = 1'b1;
          state_n       = RESP;
        end else if (count == LAST_COUNT) begin
          cyc_n         = 1'b0;
          sel_n         = 4'h0;
          rsp_dat_n     = TIMEOUT_DATA;
          rsp_timeout_n = 1'b1;
          rsp_valid_n   = 1'b1;
          state_n       = RESP;
        end else begin
          count_n = count + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          txn_n       = txn_q + 16'd1;
          ready_n     = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign cmd_ready   = ready_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_dat     = rsp_dat_q;
  assign rsp_timeout = rsp_timeout_q;
  assign txn_count   = txn_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: a scripted responder drives the bus, expected responses are
// queued at issue time and a negedge monitor checks every consumed response.
module tb_wb_initiator;

  localparam int          TO    = 16;
  localparam logic [31:0] TDATA = 32'hdeadbeef;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'h0, cmd_dat = 32'h0;
  logic        cmd_ready;
  logic        rsp_valid, rsp_timeout;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic [15:0] txn_count;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = 32'h0;

  typedef struct {
    logic [31:0] dat;
    logic        timeout;
  } rsp_t;

  rsp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_count = 16'h0;
  bit          armed = 1'b0;

  wb_initiator #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TDATA)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_timeout(rsp_timeout), .txn_count(txn_count),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: the counter is compared every cycle; a response is popped when it is consumed.
  always @(negedge wb_clk_i) begin
    rsp_t e;
    if (armed) begin
      checkOutput("txn_count", {16'h0, txn_count}, {16'h0, exp_count});
      if (wb_rst_i) begin
        exp_count = 16'h0;
        exp_q.delete();
      end else if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rsp actual=%h required=none", rsp_dat);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_dat", rsp_dat, e.dat);
          checkOutput("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.timeout});
        end
        exp_count = exp_count + 16'd1;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    if (!cmd_ready) checkOutput("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
  endtask

  // One transfer: ack is sampled at the j-th bus edge after acceptance (j > TO never acks).
  task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [31:0] rd, input int j, input bit linger,
                               input int hold, input bit bp);
    rsp_t        e;
    int          n;
    int          hold_n;
    logic [31:0] snap;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    e.timeout = (j > TO);
    e.dat     = (j > TO) ? TDATA : (we ? 32'h0 : rd);
    exp_q.push_back(e);
    @(posedge wb_clk_i); #1;
    cmd_valid = 1'b0;
    checkOutput("cyc", {31'h0, wbm_cyc_o}, 32'h1);
    checkOutput("stb", {31'h0, wbm_stb_o}, 32'h1);
    checkOutput("we", {31'h0, wbm_we_o}, {31'h0, we});
    checkOutput("sel", {28'h0, wbm_sel_o}, 32'hF);
    checkOutput("adr", wbm_adr_o, adr);
    checkOutput("wdat", wbm_dat_o, dat);
    checkOutput("cmd_ready_bus", {31'h0, cmd_ready}, 32'h0);
    n = 0;
    while (wbm_stb_o && n < 100) begin
      n++;
      wbm_ack_i = (n == j);
      wbm_dat_i = (n == j) ? rd : $urandom;
      @(posedge wb_clk_i); #1;
    end
    checkOutput("stb_cycles", n, (j > TO) ? TO : j);
    checkOutput("rsp_valid_set", {31'h0, rsp_valid}, 32'h1);
    checkOutput("sel_drop", {28'h0, wbm_sel_o}, 32'h0);
    checkOutput("adr_held", wbm_adr_o, adr);
    if (!linger) wbm_ack_i = 1'b0;
    snap   = rsp_dat;
    hold_n = (linger && hold < 1) ? 1 : hold;
    for (int i = 0; i < hold_n; i++) begin
      if (bp) begin
        cmd_valid = (i % 2 == 0);
        cmd_we    = 1'($urandom);
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
      end
      @(posedge wb_clk_i); #1;
      wbm_ack_i = 1'b0;
      if (bp) begin
        checkOutput("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        checkOutput("bp_stb", {31'h0, wbm_stb_o}, 32'h0);
        checkOutput("bp_rsp_dat", rsp_dat, snap);
        checkOutput("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      end
    end
    if (bp) cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge wb_clk_i); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    wbm_ack_i = 1'b0;
    checkOutput("rsp_valid_clear", {31'h0, rsp_valid}, 32'h0);
    if (bp) begin
      checkOutput("stb_after_release", {31'h0, wbm_stb_o}, 32'h0);
      checkOutput("cmd_ready_after_release", {31'h0, cmd_ready}, 32'h1);
    end
  endtask

  task automatic reset_mid_bus();
    wait_ready();
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h30000010;
    @(posedge wb_clk_i); #1;
    cmd_valid = 1'b0;
    checkOutput("rst_stb_before", {31'h0, wbm_stb_o}, 32'h1);
    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    checkOutput("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
    checkOutput("rst_stb", {31'h0, wbm_stb_o}, 32'h0);
    checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rst_txn_count", {16'h0, txn_count}, 32'h0);
    checkOutput("rst_cmd_ready_low", {31'h0, cmd_ready}, 32'h0);
    @(posedge wb_clk_i); #1;
    checkOutput("rst_cmd_ready_high", {31'h0, cmd_ready}, 32'h1);
  endtask

  initial begin
    repeat (3) @(posedge wb_clk_i);
    #1;
    armed = 1'b1;
    checkOutput("reset_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    checkOutput("reset_bus", {27'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o != 4'h0, rsp_valid}, 32'h0);
    checkOutput("reset_adr", wbm_adr_o, 32'h0);
    checkOutput("reset_wdat", wbm_dat_o, 32'h0);
    checkOutput("reset_rsp_dat", rsp_dat, 32'h0);
    checkOutput("reset_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    checkOutput("post_reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    applyStimulus(1'b1, 32'h3000000C, 32'h1, 32'h0, 2, 1'b0, 1, 1'b0);
    applyStimulus(1'b0, 32'h30000004, 32'h0, 32'h4669626f, 2, 1'b1, 2, 1'b0);
    applyStimulus(1'b0, 32'h30000008, 32'h0, 32'h12345678, 999, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 32'h30000000, 32'h0, 32'hcafef00d, 3, 1'b0, 10, 1'b1);
    applyStimulus(1'b0, 32'h30000014, 32'h0, 32'h0badc0de, TO, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 32'h30000018, 32'hffffffff, 32'h55aa55aa, 1, 1'b1, 0, 1'b0);

    for (int k = 0; k < 40; k++)
      applyStimulus(1'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(1, TO + 4), 1'($urandom), $urandom_range(0, 3), 1'b0);

    reset_mid_bus();

    for (int k = 0; k < 6; k++)
      applyStimulus(1'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(1, TO + 2), 1'($urandom), $urandom_range(0, 2), 1'b0);

    repeat (3) @(posedge wb_clk_i);
    #1;
    checkOutput("queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
